dmem_mmio: RTL and testbench



---
 rtl/dmem_mmio_pkg.sv | 20 ++
 rtl/dmem_mmio_if.sv | 21 ++
 rtl/mmio_tx_fifo.sv | 56 +++++
 rtl/dmem_mmio.sv | 107 ++++++++++
 tb/tb_dmem_mmio.sv | 312 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_mmio_pkg.sv
// Address map and register bit positions shared by the data-memory stage and its sub-blocks.
package dmem_mmio_pkg;

  localparam logic [31:0] MMIO_BASE   = 32'h8000_0000;
  localparam logic [31:0] ADDR_TXDATA = MMIO_BASE + 32'h00;
  localparam logic [31:0] ADDR_STATUS = MMIO_BASE + 32'h04;
  localparam logic [31:0] ADDR_TCOUNT = MMIO_BASE + 32'h08;
  localparam logic [31:0] ADDR_TCMP   = MMIO_BASE + 32'h0C;
  localparam logic [31:0] ADDR_CTRL   = MMIO_BASE + 32'h10;

  localparam int ST_EMPTY   = 0;
  localparam int ST_FULL    = 1;
  localparam int ST_OVF     = 2;
  localparam int ST_MATCH   = 3;
  localparam int ST_CNT_LSB = 4;

  localparam int CTRL_TIMER_EN = 0;
  localparam int CTRL_IRQ_EN   = 1;

endpackage

// File: rtl/dmem_mmio_if.sv
// Core-side load/store bus plus the TX byte stream and IRQ of the data-memory stage.
interface dmem_mmio_if;
  logic        MemWrite;
  logic [31:0] ALUResult;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        irq;

  modport master (
    output MemWrite, ALUResult, WriteData, tx_ready,
    input  ReadData, tx_data, tx_valid, irq
  );

  modport slave (
    input  MemWrite, ALUResult, WriteData, tx_ready,
    output ReadData, tx_data, tx_valid, irq
  );
endinterface

// File: rtl/mmio_tx_fifo.sv
// Generic circular FIFO with separate occupancy count; head shown combinationally, zero when empty.
// Push accepted when not full or when a pop happens in the same cycle; pop_vld drops when empty.
module mmio_tx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_vld,
  input  logic [WIDTH-1:0]         push_dat,
  output logic                     push_rdy,
  input  logic                     pop_rdy,
  output logic                     pop_vld,
  output logic [WIDTH-1:0]         pop_dat,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr, wr_ptr;
  logic [PW:0]      cnt;
  logic             push_do, pop_do;

  assign empty    = (cnt == '0);
  assign full     = (cnt == (PW+1)'(DEPTH));
  assign pop_vld  = !empty;
  assign pop_do   = pop_vld && pop_rdy;
  assign push_rdy = !full || pop_do;
  assign push_do  = push_vld && push_rdy;
  assign count    = cnt;
  assign pop_dat  = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push_do) wr_ptr <= wr_ptr + 1'b1;
      if (pop_do)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_do, pop_do})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage carries no reset: the head is masked while empty.
  always_ff @(posedge clk) begin
    if (push_do) mem[wr_ptr] <= push_dat;
  end

endmodule

// File: rtl/dmem_mmio.sv
// Data-memory stage: word RAM, TX byte FIFO and compare timer behind a zero-latency load path.
// Stores commit at the clock edge; a TXDATA store to a full FIFO without a pop is dropped and flagged.
module dmem_mmio
  import dmem_mmio_pkg::*;
#(
  parameter int RAM_WORDS  = 64,
  parameter int FIFO_DEPTH = 8
) (
  input  logic      clk,
  input  logic      reset,
  dmem_mmio_if.slave bus
);
  localparam int AW    = $clog2(RAM_WORDS);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic [31:0]      waddr;
  logic             sel_ram;
  logic             wr_tx, wr_status, wr_tcount, wr_tcmp, wr_ctrl;
  logic [AW-1:0]    ram_idx;
  logic [31:0]      ram [RAM_WORDS];
  logic             tx_push_rdy, fifo_full, fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  logic [31:0]      tcount, tcmp;
  logic             timer_en, irq_en, ovf, match;
  logic [31:0]      status, rdata;

  // Byte offset within a word is ignored throughout the decode.
  assign waddr     = bus.ALUResult & ~32'h3;
  assign sel_ram   = (waddr[31:8] == 24'h0);
  assign ram_idx   = waddr[2 +: AW];
  assign wr_tx     = bus.MemWrite && (waddr == ADDR_TXDATA);
  assign wr_status = bus.MemWrite && (waddr == ADDR_STATUS);
  assign wr_tcount = bus.MemWrite && (waddr == ADDR_TCOUNT);
  assign wr_tcmp   = bus.MemWrite && (waddr == ADDR_TCMP);
  assign wr_ctrl   = bus.MemWrite && (waddr == ADDR_CTRL);

  always_ff @(posedge clk) begin
    if (bus.MemWrite && sel_ram) ram[ram_idx] <= bus.WriteData;
  end

  mmio_tx_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk      (clk),
    .rst_n    (reset),
    .push_vld (wr_tx),
    .push_dat (bus.WriteData[7:0]),
    .push_rdy (tx_push_rdy),
    .pop_rdy  (bus.tx_ready),
    .pop_vld  (bus.tx_valid),
    .pop_dat  (bus.tx_data),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tcount   <= '0;
      tcmp     <= '1;
      timer_en <= 1'b0;
      irq_en   <= 1'b0;
      ovf      <= 1'b0;
      match    <= 1'b0;
    end else begin
      if (wr_tcount)     tcount <= bus.WriteData;
      else if (timer_en) tcount <= tcount + 32'd1;
      if (wr_tcmp) tcmp <= bus.WriteData;
      if (wr_ctrl) begin
        timer_en <= bus.WriteData[CTRL_TIMER_EN];
        irq_en   <= bus.WriteData[CTRL_IRQ_EN];
      end
      // A flag being set outranks a write-1-to-clear landing on the same edge.
      if (timer_en && (tcount == tcmp))             match <= 1'b1;
      else if (wr_status && bus.WriteData[ST_MATCH]) match <= 1'b0;
      if (wr_tx && !tx_push_rdy)                     ovf <= 1'b1;
      else if (wr_status && bus.WriteData[ST_OVF])   ovf <= 1'b0;
    end
  end

  assign bus.irq = match & irq_en;

  always_comb begin
    status                         = '0;
    status[ST_EMPTY]               = fifo_empty;
    status[ST_FULL]                = fifo_full;
    status[ST_OVF]                 = ovf;
    status[ST_MATCH]               = match;
    status[ST_CNT_LSB +: CNT_W]    = fifo_count;
    rdata = '0;
    if (sel_ram) begin
      rdata = ram[ram_idx];
    end else begin
      case (waddr)
        ADDR_STATUS: rdata = status;
        ADDR_TCOUNT: rdata = tcount;
        ADDR_TCMP:   rdata = tcmp;
        ADDR_CTRL: begin
          rdata[CTRL_TIMER_EN] = timer_en;
          rdata[CTRL_IRQ_EN]   = irq_en;
        end
        default:     rdata = '0;
      endcase
    end
  end

  assign bus.ReadData = rdata;

endmodule

// File: tb/tb_dmem_mmio.sv
// Directed vector table, corner-case sequences and a randomized run against a queue-based model.
module tb_dmem_mmio;
  localparam int RAM_WORDS  = 64;
  localparam int FIFO_DEPTH = 8;
  localparam logic [31:0] A_TX   = 32'h8000_0000;
  localparam logic [31:0] A_ST   = 32'h8000_0004;
  localparam logic [31:0] A_TC   = 32'h8000_0008;
  localparam logic [31:0] A_TCMP = 32'h8000_000C;
  localparam logic [31:0] A_CTRL = 32'h8000_0010;

  typedef struct {
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
    logic        rdy;
    logic        ck;
    logic [31:0] rd;
    logic        vld;
    logic [7:0]  txd;
    logic        irq;
  } vec_t;

  logic clk, reset;
  dmem_mmio_if bus_if();
  int n_assert = 0;
  int n_fail   = 0;
  vec_t vq[$];
  logic [7:0] exp_out [8];

  // Behavioural model state
  logic [7:0]  m_q[$];
  logic [31:0] m_ram [RAM_WORDS];
  logic        m_known [RAM_WORDS];
  logic [31:0] m_tc, m_tcmp;
  logic        m_en, m_irqen, m_ovf, m_match;

  dmem_mmio #(.RAM_WORDS(RAM_WORDS), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic w, input logic [31:0] a, input logic [31:0] d, input logic rdy);
    @(negedge clk);
    bus_if.MemWrite  = w;
    bus_if.ALUResult = a;
    bus_if.WriteData = d;
    bus_if.tx_ready  = rdy;
    #1;
  endtask

  function automatic vec_t mk(input logic w, input logic [31:0] a, input logic [31:0] d,
                              input logic rdy, input logic ck, input logic [31:0] rd,
                              input logic vld, input logic [7:0] txd, input logic irq);
    vec_t v;
    v.w = w; v.a = a; v.d = d; v.rdy = rdy; v.ck = ck;
    v.rd = rd; v.vld = vld; v.txd = txd; v.irq = irq;
    return v;
  endfunction

  task automatic m_reset();
    m_q.delete();
    m_tc = '0; m_tcmp = '1;
    m_en = 1'b0; m_irqen = 1'b0; m_ovf = 1'b0; m_match = 1'b0;
    for (int i = 0; i < RAM_WORDS; i++) m_known[i] = 1'b0;
  endtask

  function automatic logic [31:0] m_read(input logic [31:0] a, output logic known);
    logic [31:0] wa;
    logic [31:0] s;
    int idx;
    wa = a & ~32'h3;
    known = 1'b1;
    if (wa < 32'h100) begin
      idx = int'(wa[7:2]) % RAM_WORDS;
      known = m_known[idx];
      return m_ram[idx];
    end
    if (wa == A_ST) begin
      s = 32'(m_q.size()) << 4;
      s[3] = m_match;
      s[2] = m_ovf;
      s[1] = (m_q.size() == FIFO_DEPTH);
      s[0] = (m_q.size() == 0);
      return s;
    end
    if (wa == A_TC)   return m_tc;
    if (wa == A_TCMP) return m_tcmp;
    if (wa == A_CTRL) return {30'b0, m_irqen, m_en};
    return 32'h0;
  endfunction

  task automatic m_step(input logic w, input logic [31:0] a, input logic [31:0] d, input logic rdy);
    logic [31:0] wa;
    logic pop, can_push, mset;
    logic [7:0] gone;
    int idx;
    wa       = a & ~32'h3;
    pop      = (m_q.size() != 0) && rdy;
    can_push = (m_q.size() < FIFO_DEPTH) || pop;
    mset     = m_en && (m_tc == m_tcmp);
    if (pop) gone = m_q.pop_front();
    if (w && wa == A_TC) m_tc = d;
    else if (m_en)       m_tc = m_tc + 32'd1;
    if (w && wa < 32'h100) begin
      idx = int'(wa[7:2]) % RAM_WORDS;
      m_ram[idx] = d;
      m_known[idx] = 1'b1;
    end
    if (w && wa == A_TX) begin
      if (can_push) m_q.push_back(d[7:0]);
      else          m_ovf = 1'b1;
    end
    if (w && wa == A_ST) begin
      if (d[2]) m_ovf = 1'b0;
      if (d[3]) m_match = 1'b0;
    end
    if (mset) m_match = 1'b1;
    if (w && wa == A_TCMP) m_tcmp = d;
    if (w && wa == A_CTRL) begin
      m_en = d[0];
      m_irqen = d[1];
    end
  endtask

  initial begin : main
    int k;
    int n;
    logic found;
    vec_t v;
    logic w, rdy, kn;
    logic [31:0] a, d, erd;

    reset = 1'b0;
    bus_if.MemWrite = 1'b0; bus_if.ALUResult = '0; bus_if.WriteData = '0; bus_if.tx_ready = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // ---- vector table: RAM, reset values, FIFO fill/overflow, unmapped ----
    vq.push_back(mk(1, 32'h14, 32'h1234_5678, 0, 0, 0, 0, 8'h00, 0));
    vq.push_back(mk(1, 32'h10, 32'hDEAD_BEEF, 0, 0, 0, 0, 8'h00, 0));
    vq.push_back(mk(0, 32'h13, 0, 0, 1, 32'hDEAD_BEEF, 0, 8'h00, 0));
    vq.push_back(mk(0, 32'h14, 0, 0, 1, 32'h1234_5678, 0, 8'h00, 0));
    vq.push_back(mk(0, A_ST,   0, 0, 1, 32'h1, 0, 8'h00, 0));
    vq.push_back(mk(0, A_TCMP, 0, 0, 1, 32'hFFFF_FFFF, 0, 8'h00, 0));
    vq.push_back(mk(0, A_TC,   0, 0, 1, 32'h0, 0, 8'h00, 0));
    vq.push_back(mk(0, A_CTRL | 32'h2, 0, 0, 1, 32'h0, 0, 8'h00, 0));
    for (int b = 1; b <= 9; b++)
      vq.push_back(mk(1, A_TX, 32'hFFFF_FF00 | 32'(b), 0, 1, 32'h0, b > 1, (b > 1) ? 8'h01 : 8'h00, 0));
    vq.push_back(mk(0, A_ST, 0, 0, 1, 32'h86, 1, 8'h01, 0));
    vq.push_back(mk(1, A_ST, 32'h4, 0, 1, 32'h86, 1, 8'h01, 0));
    vq.push_back(mk(0, A_ST, 0, 0, 1, 32'h82, 1, 8'h01, 0));
    vq.push_back(mk(1, 32'h4000_0000, 32'h1234, 0, 1, 32'h0, 1, 8'h01, 0));
    vq.push_back(mk(0, 32'h4000_0000, 0, 0, 1, 32'h0, 1, 8'h01, 0));
    vq.push_back(mk(1, 32'h4000_0010, 32'hCAFE_F00D, 0, 1, 32'h0, 1, 8'h01, 0));
    vq.push_back(mk(0, 32'h10, 0, 0, 1, 32'hDEAD_BEEF, 1, 8'h01, 0));
    vq.push_back(mk(0, A_ST, 0, 0, 1, 32'h82, 1, 8'h01, 0));
    vq.push_back(mk(0, 32'h8000_0014, 0, 0, 1, 32'h0, 1, 8'h01, 0));
    for (int i = 0; i < vq.size(); i++) begin
      v = vq[i];
      drive(v.w, v.a, v.d, v.rdy);
      if (v.ck) chk($sformatf("vec%0d_rd", i), bus_if.ReadData, v.rd);
      chk($sformatf("vec%0d_vld", i), 32'(bus_if.tx_valid), 32'(v.vld));
      chk($sformatf("vec%0d_txd", i), 32'(bus_if.tx_data), 32'(v.txd));
      chk($sformatf("vec%0d_irq", i), 32'(bus_if.irq), 32'(v.irq));
    end

    // ---- full FIFO: pop and push in the same cycle, then drain ----
    drive(1, A_TX, 32'hAA, 1);
    chk("pushpop_head", 32'(bus_if.tx_data), 32'h01);
    drive(0, A_ST, 0, 0);
    chk("pushpop_status", bus_if.ReadData, 32'h82);
    chk("pushpop_newhead", 32'(bus_if.tx_data), 32'h02);
    exp_out = '{8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'hAA};
    k = 0;
    for (int c = 0; c < 20 && k < 8; c++) begin
      drive(0, A_ST, 0, 1);
      if (bus_if.tx_valid) begin
        chk($sformatf("drain%0d", k), 32'(bus_if.tx_data), 32'(exp_out[k]));
        k++;
      end
    end
    chk("drain_count", 32'(k), 32'd8);
    drive(0, A_ST, 0, 0);
    chk("drain_empty", bus_if.ReadData, 32'h1);

    // ---- count==1 with push and pop together ----
    drive(1, A_TX, 32'h55, 0);
    drive(1, A_TX, 32'h66, 1);
    chk("one_head", 32'(bus_if.tx_data), 32'h55);
    drive(0, A_ST, 0, 0);
    chk("one_status", bus_if.ReadData, 32'h10);
    chk("one_vld", 32'(bus_if.tx_valid), 32'h1);
    chk("one_newhead", 32'(bus_if.tx_data), 32'h66);
    drive(0, A_ST, 0, 1);
    drive(0, A_ST, 0, 0);
    chk("one_drained", bus_if.ReadData, 32'h1);

    // ---- timer compare, IRQ, clear, wrap ----
    drive(1, A_TCMP, 32'd5, 0);
    drive(1, A_TC, 32'd0, 0);
    drive(1, A_CTRL, 32'h3, 0);
    found = 1'b0;
    n = 0;
    for (int c = 0; c < 20 && !found; c++) begin
      drive(0, A_TC, 0, 0);
      if (bus_if.irq) begin
        found = 1'b1;
        n = c;
        chk("irq_tcount", bus_if.ReadData, 32'd6);
      end
    end
    chk("irq_seen", 32'(found), 32'h1);
    chk("irq_cycle", 32'(n), 32'd6);
    drive(1, A_ST, 32'h8, 0);
    chk("match_status", bus_if.ReadData, 32'h9);
    drive(0, A_CTRL, 0, 0);
    chk("irq_cleared", 32'(bus_if.irq), 32'h0);
    chk("ctrl_read", bus_if.ReadData, 32'h3);
    drive(1, A_TC, 32'hFFFF_FFFF, 0);
    drive(0, A_TC, 0, 0);
    chk("wrap_pre", bus_if.ReadData, 32'hFFFF_FFFF);
    drive(0, A_TC, 0, 0);
    chk("wrap_post", bus_if.ReadData, 32'h0);

    // ---- asynchronous reset between edges ----
    drive(1, A_TC, 32'd0, 0);
    drive(1, A_TCMP, 32'd4, 0);
    drive(1, A_TX, 32'h11, 0);
    drive(1, A_TX, 32'h22, 0);
    drive(1, A_TX, 32'h33, 0);
    drive(0, A_ST, 0, 0);
    chk("pre_rst_status", bus_if.ReadData, 32'h30);
    drive(0, A_ST, 0, 0);
    chk("pre_rst_irq", 32'(bus_if.irq), 32'h1);
    chk("pre_rst_match", bus_if.ReadData, 32'h38);
    #1 reset = 1'b0;
    #1;
    chk("rst_vld", 32'(bus_if.tx_valid), 32'h0);
    chk("rst_txd", 32'(bus_if.tx_data), 32'h0);
    chk("rst_irq", 32'(bus_if.irq), 32'h0);
    chk("rst_status", bus_if.ReadData, 32'h1);
    bus_if.ALUResult = A_TC;
    #1;
    chk("rst_tcount", bus_if.ReadData, 32'h0);
    @(negedge clk);
    reset = 1'b1;

    // ---- randomized run against the model ----
    @(negedge clk);
    reset = 1'b0;
    #1;
    @(negedge clk);
    reset = 1'b1;
    m_reset();
    for (int i = 0; i < 3000; i++) begin
      w   = 1'($urandom_range(0, 1));
      rdy = (i < 1500) ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 1) == 1);
      d   = $urandom;
      case ($urandom_range(0, 9))
        0, 1:    a = $urandom_range(0, 255);
        2, 3, 4: a = A_TX | $urandom_range(0, 3);
        5:       a = A_ST | $urandom_range(0, 3);
        6: begin
          a = A_TC;
          d = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8 + $urandom_range(0, 7) : $urandom_range(0, 31);
        end
        7: begin
          a = A_TCMP;
          d = $urandom_range(0, 40);
        end
        8:       a = A_CTRL | $urandom_range(0, 3);
        default: begin
          case ($urandom_range(0, 3))
            0:       a = 32'h4000_0000 + $urandom_range(0, 255);
            1:       a = 32'h8000_0014 + 4 * $urandom_range(0, 50);
            2:       a = 32'h0000_0100 + $urandom_range(0, 1023);
            default: a = 32'hFFFF_FFFC;
          endcase
        end
      endcase
      drive(w, a, d, rdy);
      erd = m_read(a, kn);
      if (kn) chk($sformatf("rnd%0d_rd@%08h", i, a), bus_if.ReadData, erd);
      chk($sformatf("rnd%0d_vld", i), 32'(bus_if.tx_valid), 32'(m_q.size() != 0));
      chk($sformatf("rnd%0d_txd", i), 32'(bus_if.tx_data), 32'((m_q.size() != 0) ? m_q[0] : 8'h00));
      chk($sformatf("rnd%0d_irq", i), 32'(bus_if.irq), 32'(m_match & m_irqen));
      m_step(w, a, d, rdy);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
